edge_detect_mc: RTL and testbench
=================================

// Module: edge_detect_mc
// PURPOSE
//  Parametrised multi-channel edge detector for asynchronous level inputs.
//  Per channel: metastability synchroniser, glitch filter, registered rise/down pulses.
//  Also per channel: mode-qualified event pulse, sticky flag, saturating event counter.
//  Sits between raw pins/async status lines and the control/interrupt logic.
// PARAMETERS
//  CH           4  number of independent channels (>=1)
//  SYNC_STAGES  2  synchroniser flops per channel (>=2)
//  FILT_CYC     3  consecutive cycles a new synced level must hold before acceptance (>=1; 1 = no filtering)
//  CNT_W        8  per-channel event counter width (>=1)
// PORTS
//  clk      in   1           system clock, all logic on rising edge
//  rst_n    in   1           reset, synchronous, active-low
//  a        in   CH          asynchronous level inputs, bit i = channel i
//  mode     in   2           event select: 00 none, 01 rise, 10 fall, 11 both
//  clr      in   CH          per-channel clear of sticky and cnt (level, acts each cycle high)
//  rise     out  CH          1-cycle pulse on accepted 0->1 transition
//  down     out  CH          1-cycle pulse on accepted 1->0 transition
//  evt      out  CH          1-cycle pulse on accepted transition matching mode
//  sticky   out  CH          set by evt, held until clr
//  cnt      out  CH*CNT_W    channel i count at [i*CNT_W +: CNT_W], saturating
//  irq      out  1           OR of all sticky bits (combinational from registers)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): sync chains, filtered level f, filter counters = 0.
//    Also cleared: rise, down, evt, sticky, cnt = 0, so irq = 0. Reset wins over all other inputs.
//  - Sync: s = last stage of SYNC_STAGES-flop chain on a[i]; no other logic on unsynced a.
//  - Filter per channel: two states, STABLE_LO (f=0) and STABLE_HI (f=1), plus counter fc.
//    - Each edge with s!=f: fc increments.
//    - On the edge where s!=f and fc==FILT_CYC-1: f toggles, fc<=0.
//    - Each edge with s==f: fc<=0, so any glitch shorter than FILT_CYC cycles is dropped.
//    - fc width = clog2(FILT_CYC)+1 minimum; never wraps.
//  - Pulses are registered on the same edge f toggles:
//    - rise <= f_next & ~f; down <= ~f_next & f.
//    - Each is high exactly one cycle per transition. rise and down are never both high.
//  - Latency: E0 = first edge sampling the new a level into stage 0.
//    rise/down/evt visible after edge E(SYNC_STAGES+FILT_CYC-1); defaults = 5th edge.
//  - evt <= (mode[0] & rise_next) | (mode[1] & down_next); same cycle as rise/down.
//  - mode is sampled every edge; a change applies to the next accepted transition only.
//  - mode=00: evt never fires; sticky and cnt hold.
//  - sticky[i]: set on evt[i]; cleared by clr[i].
//  - cnt[i]: +1 per evt[i]; holds at 2^CNT_W-1 (no wrap).
//  - clr[i] with evt[i] on the same edge: event wins, so sticky=1 and cnt=1; no event is lost.
//  - After reset f=0, so an input held high through reset reports one rise (intended).
//  - Reset mid-filter: pending transition discarded; channels fully independent.
// TESTING
//  1. Defaults, a[0] 0->1 held: rise[0] high one cycle after 5th edge.
//     Also evt[0]=1 with mode=01, sticky[0]=1, cnt[0]=1, irq=1; other channels 0.
//  2. a[1] high-going glitch of 2 cycles (FILT_CYC=3): no rise, down, evt, or cnt change.
//     Then a 3-cycle pulse: one rise and, later, one down.
//  3. mode=11, toggle a[2] 4 times at 10-cycle spacing: rise x2, down x2, cnt[2]=4.
//     Repeat with mode=01: cnt increments only on rises.
//  4. CNT_W=2, 5 accepted events: cnt saturates at 3; clr pulse -> cnt=0, sticky=0, irq=0.
//  5. clr[3] asserted on the same edge as evt[3]: sticky[3]=1, cnt[3]=1.
//  6. rst_n=0 for one edge mid-filter (fc=2): all outputs 0 next cycle; the pending edge is not reported.
//     Input held at 1 through reset: exactly one rise is reported after release.

Source files
------------

// File: rtl/edge_detect_mc.sv
// ---------------------------------------------------------------------------
// edge_detect_mc
//
// Multi-channel edge detector for asynchronous level inputs. Each channel
// synchronises its raw input, filters out short glitches, and reports
// accepted transitions as registered one-cycle rise/down pulses. A
// mode-qualified event pulse drives a per-channel sticky flag and a
// saturating event counter. The OR of all sticky flags forms the interrupt.
//
// Parameters
//   CH           number of independent channels (>=1)
//   SYNC_STAGES  synchroniser flops per channel (>=2)
//   FILT_CYC     cycles a new synced level must hold before acceptance (>=1)
//   CNT_W        per-channel event counter width (>=1)
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   a       in   [CH]        asynchronous level inputs
//   mode    in   [2]         event select: 00 none, 01 rise, 10 fall, 11 both
//   clr     in   [CH]        per-channel clear of sticky and cnt (level)
//   rise    out  [CH]        one-cycle pulse on accepted 0->1
//   down    out  [CH]        one-cycle pulse on accepted 1->0
//   evt     out  [CH]        one-cycle pulse on accepted transition matching mode
//   sticky  out  [CH]        set by evt, held until clr
//   cnt     out  [CH*CNT_W]  channel i count at [i*CNT_W +: CNT_W], saturating
//   irq     out  1           OR of all sticky bits
// ---------------------------------------------------------------------------
module edge_detect_mc #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       a,
    input  logic [1:0]          mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       rise,
    output logic [CH-1:0]       down,
    output logic [CH-1:0]       evt,
    output logic [CH-1:0]       sticky,
    output logic [CH*CNT_W-1:0] cnt,
    output logic                irq
);

    // One extra bit beyond clog2 so the filter counter can never wrap.
    localparam int               FC_W    = $clog2(FILT_CYC) + 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } filt_state_e;

    logic [SYNC_STAGES-1:0]    syncChain_q [CH];
    logic [CH-1:0]             syncLvl;
    filt_state_e               filtState_q [CH];
    filt_state_e               filtState_d [CH];
    logic [FC_W-1:0]           filtCnt_q   [CH];
    logic [FC_W-1:0]           filtCnt_d   [CH];
    logic [CH-1:0]             filtLvl;
    logic [CH-1:0]             filtLvl_d;
    logic [CH-1:0]             rise_q, rise_d;
    logic [CH-1:0]             down_q, down_d;
    logic [CH-1:0]             evt_q, evt_d;
    logic [CH-1:0]             sticky_q, sticky_d;
    logic [CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state logic for every channel. The glitch filter only accepts a
    // new synced level once it has differed from the filtered level for
    // FILT_CYC consecutive edges; any return to the filtered level restarts
    // the count. Pulses are derived from the filtered level changing on this
    // edge, so rise/down/evt all appear in the same cycle. When a clear and
    // an event coincide, the clear is applied first and the event is then
    // counted, so no event is ever lost.
    always_comb begin
        syncLvl   = '0;
        filtLvl   = '0;
        filtLvl_d = '0;
        rise_d    = '0;
        down_d    = '0;
        evt_d     = '0;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        for (int i = 0; i < CH; i++) begin
            syncLvl[i]     = syncChain_q[i][SYNC_STAGES-1];
            filtLvl[i]     = (filtState_q[i] == STABLE_HI);
            filtState_d[i] = filtState_q[i];
            filtCnt_d[i]   = '0;

            if (syncLvl[i] != filtLvl[i]) begin
                if (filtCnt_q[i] == FC_LAST) begin
                    filtState_d[i] = filtLvl[i] ? STABLE_LO : STABLE_HI;
                end else begin
                    filtCnt_d[i] = filtCnt_q[i] + FC_W'(1);
                end
            end

            filtLvl_d[i] = (filtState_d[i] == STABLE_HI);
            rise_d[i]    = filtLvl_d[i] & ~filtLvl[i];
            down_d[i]    = ~filtLvl_d[i] & filtLvl[i];
            evt_d[i]     = (mode[0] & rise_d[i]) | (mode[1] & down_d[i]);

            if (clr[i]) begin
                sticky_d[i] = evt_d[i];
                cnt_d[i]    = evt_d[i] ? CNT_W'(1) : '0;
            end else if (evt_d[i]) begin
                sticky_d[i] = 1'b1;
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // All state registers, including the synchronisers. Reset clears every
    // channel, discarding any transition that was partway through the filter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                syncChain_q[i] <= '0;
                filtState_q[i] <= STABLE_LO;
                filtCnt_q[i]   <= '0;
            end
            rise_q   <= '0;
            down_q   <= '0;
            evt_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                syncChain_q[i] <= {syncChain_q[i][SYNC_STAGES-2:0], a[i]};
                filtState_q[i] <= filtState_d[i];
                filtCnt_q[i]   <= filtCnt_d[i];
            end
            rise_q   <= rise_d;
            down_q   <= down_d;
            evt_q    <= evt_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rise   = rise_q;
    assign down   = down_q;
    assign evt    = evt_q;
    assign sticky = sticky_q;
    assign cnt    = cnt_q;
    assign irq    = |sticky_q;

endmodule

// File: tb/tb_edge_detect_mc.sv
// ---------------------------------------------------------------------------
// tb_edge_detect_mc
//
// Self-checking bench for edge_detect_mc. A default-parameter instance is
// driven by a table of per-channel transitions plus hand-written sequences
// for exact latency, glitch rejection, clear/event collision and reset
// mid-filter. A second single-channel instance with a 2-bit counter covers
// counter saturation.
// ---------------------------------------------------------------------------
module tb_edge_detect_mc;

    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [CH-1:0]       a;
    logic [1:0]          mode;
    logic [CH-1:0]       clr;
    logic [CH-1:0]       rise;
    logic [CH-1:0]       down;
    logic [CH-1:0]       evt;
    logic [CH-1:0]       sticky;
    logic [CH*CNT_W-1:0] cnt;
    logic                irq;

    logic       sA;
    logic [1:0] sMode;
    logic       sClr;
    logic       sRise;
    logic       sDown;
    logic       sEvt;
    logic       sSticky;
    logic [1:0] sCnt;
    logic       sIrq;

    edge_detect_mc #(
        .CH(CH), .SYNC_STAGES(2), .FILT_CYC(3), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .mode(mode), .clr(clr),
        .rise(rise), .down(down), .evt(evt), .sticky(sticky),
        .cnt(cnt), .irq(irq)
    );

    edge_detect_mc #(
        .CH(1), .SYNC_STAGES(2), .FILT_CYC(3), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .a(sA), .mode(sMode), .clr(sClr),
        .rise(sRise), .down(sDown), .evt(sEvt), .sticky(sSticky),
        .cnt(sCnt), .irq(sIrq)
    );

    typedef struct {
        int         ch;
        logic       lvl;
        logic [1:0] md;
        int         cyc;
        int         eRise;
        int         eDown;
        int         eEvt;
        int         eCnt;
    } vec_t;

    vec_t vecs [12];

    int checks    = 0;
    int passes    = 0;
    int bothHigh  = 0;
    int riseCnt [CH];
    int downCnt [CH];
    int evtCnt  [CH];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCounts();
        for (int c = 0; c < CH; c++) begin
            riseCnt[c] = 0;
            downCnt[c] = 0;
            evtCnt[c]  = 0;
        end
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            for (int c = 0; c < CH; c++) begin
                riseCnt[c] += int'(rise[c]);
                downCnt[c] += int'(down[c]);
                evtCnt[c]  += int'(evt[c]);
            end
            if ((rise & down) != '0) bothHigh++;
        end
    endtask

    function automatic int getCnt(input int ch);
        return int'(cnt[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic applyStimulus(input int ch, input logic lvl, input logic [1:0] md);
        a[ch] = lvl;
        mode  = md;
    endtask

    initial begin
        rst_n = 1'b0;
        a     = '0;
        mode  = 2'b01;
        clr   = '0;
        sA    = 1'b0;
        sMode = 2'b11;
        sClr  = 1'b0;

        // ch, level, mode, cycles, rise, down, evt, final cnt
        vecs[0]  = '{2, 1'b1, 2'b11, 10, 1, 0, 1, 1};
        vecs[1]  = '{2, 1'b0, 2'b11, 10, 0, 1, 1, 2};
        vecs[2]  = '{2, 1'b1, 2'b11, 10, 1, 0, 1, 3};
        vecs[3]  = '{2, 1'b0, 2'b11, 10, 0, 1, 1, 4};
        vecs[4]  = '{2, 1'b1, 2'b01, 10, 1, 0, 1, 5};
        vecs[5]  = '{2, 1'b0, 2'b01, 10, 0, 1, 0, 5};
        vecs[6]  = '{2, 1'b1, 2'b01, 10, 1, 0, 1, 6};
        vecs[7]  = '{2, 1'b0, 2'b01, 10, 0, 1, 0, 6};
        vecs[8]  = '{3, 1'b1, 2'b10, 10, 1, 0, 0, 0};
        vecs[9]  = '{3, 1'b0, 2'b10, 10, 0, 1, 1, 1};
        vecs[10] = '{0, 1'b0, 2'b00, 10, 0, 1, 0, 1};
        vecs[11] = '{1, 1'b1, 2'b10, 10, 1, 0, 0, 2};

        // Reset state
        repeat (3) tick();
        checkOutput("reset_rise",   int'(rise),   0);
        checkOutput("reset_down",   int'(down),   0);
        checkOutput("reset_evt",    int'(evt),    0);
        checkOutput("reset_sticky", int'(sticky), 0);
        checkOutput("reset_cnt",    int'(cnt != '0), 0);
        checkOutput("reset_irq",    int'(irq),    0);
        checkOutput("reset_satCnt", int'(sCnt),   0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Exact latency: rise appears after the 5th edge following the change
        applyStimulus(0, 1'b1, 2'b01);
        repeat (4) tick();
        checkOutput("lat_rise_early", int'(rise[0]), 0);
        tick();
        checkOutput("lat_rise0",   int'(rise[0]),    1);
        checkOutput("lat_evt0",    int'(evt[0]),     1);
        checkOutput("lat_sticky0", int'(sticky[0]),  1);
        checkOutput("lat_cnt0",    getCnt(0),        1);
        checkOutput("lat_irq",     int'(irq),        1);
        checkOutput("lat_others",  int'(rise[3:1]),  0);
        checkOutput("lat_cnt1",    getCnt(1),        0);
        tick();
        checkOutput("lat_rise_gone", int'(rise[0]),  0);
        checkOutput("lat_sticky_held", int'(sticky[0]), 1);

        // Two-cycle glitch is dropped, three-cycle pulse is accepted
        clearCounts();
        applyStimulus(1, 1'b1, 2'b11);
        runCycles(2);
        a[1] = 1'b0;
        runCycles(12);
        checkOutput("glitch_rise", riseCnt[1], 0);
        checkOutput("glitch_down", downCnt[1], 0);
        checkOutput("glitch_evt",  evtCnt[1],  0);
        checkOutput("glitch_cnt",  getCnt(1),  0);
        clearCounts();
        a[1] = 1'b1;
        runCycles(3);
        a[1] = 1'b0;
        runCycles(15);
        checkOutput("pulse3_rise", riseCnt[1], 1);
        checkOutput("pulse3_down", downCnt[1], 1);
        checkOutput("pulse3_evt",  evtCnt[1],  2);
        checkOutput("pulse3_cnt",  getCnt(1),  2);

        // Table-driven transitions
        for (int r = 0; r < 12; r++) begin
            clearCounts();
            applyStimulus(vecs[r].ch, vecs[r].lvl, vecs[r].md);
            runCycles(vecs[r].cyc);
            checkOutput($sformatf("row%0d_rise", r), riseCnt[vecs[r].ch], vecs[r].eRise);
            checkOutput($sformatf("row%0d_down", r), downCnt[vecs[r].ch], vecs[r].eDown);
            checkOutput($sformatf("row%0d_evt",  r), evtCnt[vecs[r].ch],  vecs[r].eEvt);
            checkOutput($sformatf("row%0d_cnt",  r), getCnt(vecs[r].ch),  vecs[r].eCnt);
        end
        checkOutput("table_sticky", int'(sticky), 15);
        checkOutput("table_irq",    int'(irq),    1);

        // Clear everything
        clr = '1;
        tick();
        clr = '0;
        checkOutput("clrall_sticky", int'(sticky),    0);
        checkOutput("clrall_irq",    int'(irq),       0);
        checkOutput("clrall_cnt",    int'(cnt != '0), 0);

        // Counter saturation on the 2-bit instance
        for (int k = 1; k <= 5; k++) begin
            sA = ~sA;
            repeat (10) tick();
            checkOutput($sformatf("sat_cnt_%0d", k), int'(sCnt), (k < 3) ? k : 3);
        end
        checkOutput("sat_sticky", int'(sSticky), 1);
        checkOutput("sat_irq",    int'(sIrq),    1);
        sClr = 1'b1;
        tick();
        sClr = 1'b0;
        checkOutput("sat_clr_cnt",    int'(sCnt),    0);
        checkOutput("sat_clr_sticky", int'(sSticky), 0);
        checkOutput("sat_clr_irq",    int'(sIrq),    0);

        // Clear held through the edge where an event is registered
        clr = 4'b1000;
        applyStimulus(3, 1'b1, 2'b11);
        repeat (4) tick();
        checkOutput("coll_pre_evt", int'(evt[3]), 0);
        tick();
        clr = '0;
        checkOutput("coll_evt3",    int'(evt[3]),    1);
        checkOutput("coll_sticky3", int'(sticky[3]), 1);
        checkOutput("coll_cnt3",    getCnt(3),       1);
        tick();
        checkOutput("coll_sticky3_held", int'(sticky[3]), 1);
        checkOutput("coll_cnt3_held",    getCnt(3),       1);

        // Reset mid-filter with the input held high
        applyStimulus(0, 1'b1, 2'b01);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_rise",   int'(rise),      0);
        checkOutput("midrst_down",   int'(down),      0);
        checkOutput("midrst_evt",    int'(evt),       0);
        checkOutput("midrst_sticky", int'(sticky),    0);
        checkOutput("midrst_cnt",    int'(cnt != '0), 0);
        checkOutput("midrst_irq",    int'(irq),       0);
        clearCounts();
        runCycles(4);
        checkOutput("postrst_early_rise", riseCnt[0], 0);
        tick();
        checkOutput("postrst_rise0", int'(rise[0]), 1);
        checkOutput("postrst_evt0",  int'(evt[0]),  1);
        checkOutput("postrst_cnt0",  getCnt(0),     1);
        clearCounts();
        runCycles(10);
        checkOutput("postrst_no_more_rise", riseCnt[0], 0);
        checkOutput("postrst_no_down",      downCnt[0], 0);

        checkOutput("rise_down_exclusive", bothHigh, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
